// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and stall controller for a five-stage in-order pipeline.
//   It produces the write enables for the PC and the pipeline registers,
//   the bubble-insertion flushes, the halted flag and a saturating count
//   of stall cycles.
//
// Ports
//   clk, rst             : clock; asynchronous active-low reset
//   ifid_rs/rt/uses_rt   : source registers of the ID instruction
//   ifid_halt            : ID instruction is HLT
//   idex_memread/rd      : EX instruction is a load, and its destination
//   branch_taken         : branch resolved taken in ID
//   imem_busy/dmem_busy  : instruction / data memory access still pending
//   memwb_halt           : HLT has reached WB
//   *_wen, *_flush       : pipeline register write enables and flushes
//   hlt                  : processor halted
//   stall_cnt            : stall cycles since reset (saturating)
//
// state   | meaning
// --------+---------------------------------------------------------------
// RUN     | normal flow; load-use, branch and halt detection active
// DSTALL  | data memory busy, whole pipe frozen
// ISTALL  | instruction fetch busy, bubbles fed into IFID
// DRAIN   | HLT accepted, PC held while older instructions retire
// HALTED  | HLT retired, everything frozen until reset
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       ifid_rs,
    input  logic [3:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             ifid_halt,
    input  logic             idex_memread,
    input  logic [3:0]       idex_rd,
    input  logic             branch_taken,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    input  logic             memwb_halt,
    output logic             pc_wen,
    output logic             ifid_wen,
    output logic             idex_wen,
    output logic             exmem_wen,
    output logic             memwb_wen,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             hlt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [2:0] S_RUN    = 3'd0;
    localparam logic [2:0] S_DSTALL = 3'd1;
    localparam logic [2:0] S_ISTALL = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    logic [2:0]       state_q, state_d;
    logic             halt_pend_q, halt_pend_d;
    logic             ld_stall_q, ld_stall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;

    // After a load-use bubble the IDEX slot holds a NOP, so a hazard seen in
    // the very next cycle can only be stale inputs; it is suppressed so each
    // hazard costs exactly one cycle.
    assign load_use = idex_memread && (idex_rd != 4'd0) && !ld_stall_q &&
                      ((idex_rd == ifid_rs) || (ifid_uses_rt && (idex_rd == ifid_rt)));

    always_comb begin
        pc_wen      = 1'b1;
        ifid_wen    = 1'b1;
        idex_wen    = 1'b1;
        exmem_wen   = 1'b1;
        memwb_wen   = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        ld_stall_d  = 1'b0;
        state_d     = state_q;

        if (state_q == S_HALTED) begin
            pc_wen    = 1'b0;
            ifid_wen  = 1'b0;
            idex_wen  = 1'b0;
            exmem_wen = 1'b0;
            memwb_wen = 1'b0;
        end else if (dmem_busy) begin
            pc_wen    = 1'b0;
            ifid_wen  = 1'b0;
            idex_wen  = 1'b0;
            exmem_wen = 1'b0;
            memwb_wen = 1'b0;
            state_d   = S_DSTALL;
        end else begin
            if (halt_pend_q) begin
                // Draining (possibly resuming from a data stall): hold PC,
                // keep feeding bubbles, let older stages retire.
                pc_wen     = 1'b0;
                ifid_flush = 1'b1;
                state_d    = S_DRAIN;
            end else if (imem_busy) begin
                // The ID instruction still advances, so an HLT in ID is
                // accepted here as well.
                pc_wen     = 1'b0;
                ifid_flush = 1'b1;
                state_d    = ifid_halt ? S_DRAIN : S_ISTALL;
            end else if (load_use) begin
                pc_wen     = 1'b0;
                ifid_wen   = 1'b0;
                idex_flush = 1'b1;
                ld_stall_d = 1'b1;
                state_d    = S_RUN;
            end else if (ifid_halt) begin
                ifid_flush = 1'b1;
                state_d    = S_DRAIN;
            end else begin
                ifid_flush = branch_taken;
                state_d    = S_RUN;
            end
            if (memwb_halt) begin
                state_d = S_HALTED;
            end
        end

        if (!rst) begin
            pc_wen     = 1'b0;
            ifid_wen   = 1'b0;
            idex_wen   = 1'b0;
            exmem_wen  = 1'b0;
            memwb_wen  = 1'b0;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
        end
    end

    always_comb begin
        halt_pend_d = halt_pend_q || (state_d == S_DRAIN);
        cnt_d       = cnt_q;
        if (!pc_wen && (state_q != S_HALTED) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_RUN;
            halt_pend_q <= 1'b0;
            ld_stall_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            halt_pend_q <= halt_pend_d;
            ld_stall_q  <= ld_stall_d;
            cnt_q       <= cnt_d;
        end
    end

    assign hlt       = (state_q == S_HALTED);
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    ifid_rs, ifid_rt, idex_rd;
    logic          ifid_uses_rt, ifid_halt, idex_memread, branch_taken;
    logic          imem_busy, dmem_busy, memwb_halt;
    logic          pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen;
    logic          ifid_flush, idex_flush, hlt;
    logic [CW-1:0] stall_cnt;

    typedef struct {
        string      name;
        logic [11:0] v;   // {wen[4:0], flush[1:0], hlt, stall_cnt[3:0]}
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    pipe_hazard_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .ifid_halt(ifid_halt), .idex_memread(idex_memread), .idex_rd(idex_rd),
        .branch_taken(branch_taken), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
        .memwb_halt(memwb_halt),
        .pc_wen(pc_wen), .ifid_wen(ifid_wen), .idex_wen(idex_wen),
        .exmem_wen(exmem_wen), .memwb_wen(memwb_wen),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .hlt(hlt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are combinational and settle after the inputs change
    // at negedge+1; compare everything queued for this cycle at negedge+3,
    // well before the next posedge.
    initial begin
        exp_t        e;
        logic [11:0] act;
        forever begin
            @(negedge clk);
            #3;
            while (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
                       ifid_flush, idex_flush, hlt, stall_cnt};
                tests++;
                if (act !== e.v) begin
                    fails++;
                    $display("FAIL %s: got wen=%b flush=%b hlt=%b cnt=%0d, want wen=%b flush=%b hlt=%b cnt=%0d",
                             e.name, act[11:7], act[6:5], act[4], act[3:0],
                             e.v[11:7], e.v[6:5], e.v[4], e.v[3:0]);
                end
            end
        end
    end

    task automatic clr_in();
        ifid_rs = 4'd0; ifid_rt = 4'd0; ifid_uses_rt = 1'b0; ifid_halt = 1'b0;
        idex_memread = 1'b0; idex_rd = 4'd0; branch_taken = 1'b0;
        imem_busy = 1'b0; dmem_busy = 1'b0; memwb_halt = 1'b0;
    endtask

    // Queue the expected response for the inputs currently applied, then
    // advance to the next cycle's input slot (negedge+1).
    task automatic expect_cyc(input string nm, input logic [4:0] w,
                              input logic [1:0] f, input logic h, input logic [3:0] c);
        exp_t e;
        e.name = nm;
        e.v    = {w, f, h, c};
        sb_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        clr_in();
        @(negedge clk);
        #1;

        // Reset state
        expect_cyc("reset", 5'b00000, 2'b00, 1'b0, 4'd0);
        rst = 1'b1;
        expect_cyc("run_idle", 5'b11111, 2'b00, 1'b0, 4'd0);

        // Load-use on Rs
        idex_memread = 1'b1; idex_rd = 4'd3; ifid_rs = 4'd3;
        expect_cyc("luse_rs", 5'b00111, 2'b01, 1'b0, 4'd0);
        clr_in();
        expect_cyc("luse_after", 5'b11111, 2'b00, 1'b0, 4'd1);
        // Load-use on Rt, inputs held a second cycle: still one bubble only
        idex_memread = 1'b1; idex_rd = 4'd5; ifid_rt = 4'd5; ifid_uses_rt = 1'b1; ifid_rs = 4'd1;
        expect_cyc("luse_rt", 5'b00111, 2'b01, 1'b0, 4'd1);
        expect_cyc("luse_once", 5'b11111, 2'b00, 1'b0, 4'd2);
        ifid_uses_rt = 1'b0;
        expect_cyc("rt_unused", 5'b11111, 2'b00, 1'b0, 4'd2);
        // R0 exempt
        clr_in();
        idex_memread = 1'b1; idex_rd = 4'd0; ifid_rs = 4'd0;
        expect_cyc("r0_exempt", 5'b11111, 2'b00, 1'b0, 4'd2);
        // Branch ignored under load-use, then honoured alone
        idex_rd = 4'd3; ifid_rs = 4'd3; branch_taken = 1'b1;
        expect_cyc("br_luse", 5'b00111, 2'b01, 1'b0, 4'd2);
        idex_memread = 1'b0;
        expect_cyc("branch", 5'b11111, 2'b10, 1'b0, 4'd3);
        clr_in();
        expect_cyc("run_again", 5'b11111, 2'b00, 1'b0, 4'd3);

        // Data stall with a taken branch: full freeze, no flush
        rst = 1'b0;
        expect_cyc("rst_clr", 5'b00000, 2'b00, 1'b0, 4'd0);
        rst = 1'b1;
        dmem_busy = 1'b1; branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) expect_cyc("dstall", 5'b00000, 2'b00, 1'b0, 4'(i));
        clr_in();
        expect_cyc("dstall_exit", 5'b11111, 2'b00, 1'b0, 4'd4);
        // dmem and imem together: data stall first, fetch stall after
        dmem_busy = 1'b1; imem_busy = 1'b1;
        expect_cyc("both_busy", 5'b00000, 2'b00, 1'b0, 4'd4);
        dmem_busy = 1'b0;
        expect_cyc("istall_after", 5'b01111, 2'b10, 1'b0, 4'd5);
        clr_in();
        expect_cyc("istall_exit", 5'b11111, 2'b00, 1'b0, 4'd6);

        // Saturation: fetch stall for 20 cycles
        rst = 1'b0;
        expect_cyc("rst_sat", 5'b00000, 2'b00, 1'b0, 4'd0);
        rst = 1'b1;
        imem_busy = 1'b1;
        for (int i = 0; i < 20; i++) expect_cyc("sat", 5'b01111, 2'b10, 1'b0, 4'((i > 15) ? 15 : i));
        clr_in();
        expect_cyc("sat_hold", 5'b11111, 2'b00, 1'b0, 4'd15);

        // Halt sequence with a data stall while draining
        rst = 1'b0;
        expect_cyc("rst_halt", 5'b00000, 2'b00, 1'b0, 4'd0);
        rst = 1'b1;
        ifid_halt = 1'b1;
        expect_cyc("halt_id", 5'b11111, 2'b10, 1'b0, 4'd0);
        clr_in();
        expect_cyc("drain", 5'b01111, 2'b10, 1'b0, 4'd0);
        dmem_busy = 1'b1;
        expect_cyc("drain_dstall", 5'b00000, 2'b00, 1'b0, 4'd1);
        dmem_busy = 1'b0; memwb_halt = 1'b1;
        expect_cyc("drain_resume", 5'b01111, 2'b10, 1'b0, 4'd2);
        clr_in();
        for (int i = 0; i < 12; i++) begin
            imem_busy = 1'(i % 2); branch_taken = 1'(i % 3 == 0);
            expect_cyc("halted", 5'b00000, 2'b00, 1'b1, 4'd3);
        end

        // Async reset between edges during HALTED
        rst = 1'b0;
        expect_cyc("async_rst", 5'b00000, 2'b00, 1'b0, 4'd0);
        clr_in();
        rst = 1'b1;
        expect_cyc("post_rst", 5'b11111, 2'b00, 1'b0, 4'd0);

        repeat (2) @(negedge clk);
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: got %0d entries left, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
